// File: rtl/btn_conditioner.sv
// Button conditioner: synchronises a raw button level, debounces it with a
// counter-based FSM and emits a clean level, edge pulses and a press count.
module btn_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_in,
  output logic                   level_out,
  output logic                   rise_out,
  output logic                   fall_out,
  output logic [COUNT_WIDTH-1:0] press_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH   = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW    = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: the only logic that ever sees btn_in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Debounce FSM next state; a candidate value needs DEBOUNCE_CYCLES
  // consecutive synchronised samples, the first of which loads cnt with 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      STABLE_LOW: begin
        if (sync_s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = {CW{1'b0}};
        end
      end
      WAIT_HIGH: begin
        if (!sync_s) begin
          state_d = STABLE_LOW;
          cnt_d   = {CW{1'b0}};
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = STABLE_HIGH;
          cnt_d   = {CW{1'b0}};
          level_d = 1'b1;
          rise_d  = 1'b1;
          count_d = count_q + COUNT_WIDTH'(1);
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sync_s) begin
          state_d = WAIT_LOW;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = {CW{1'b0}};
        end
      end
      WAIT_LOW: begin
        if (sync_s) begin
          state_d = STABLE_HIGH;
          cnt_d   = {CW{1'b0}};
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = STABLE_LOW;
          cnt_d   = {CW{1'b0}};
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = {CW{1'b0}};
        level_d = 1'b0;
      end
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE_LOW;
      cnt_q   <= {CW{1'b0}};
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign level_out   = level_q;
  assign rise_out    = rise_q;
  assign fall_out    = fall_q;
  assign press_count = count_q;

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the flip-flop lab block.
- Takes a raw, asynchronous, bouncy push-button/switch signal and synchronises it to clk.
- Debounces it with a counter-based state machine.
- Produces a clean level, single-cycle rise/fall pulses and a wrapping press counter. The clean level drives the flip-flop stage's data input.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btn_in. Legal range ≥ 2.
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles of a new value required before it is accepted. Legal range ≥ 2. Small default for simulation; boards use ~500000.
- COUNT_WIDTH, 8, width of press_count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_in  input  1  raw asynchronous button level; may glitch or bounce.
- level_out  output  1  debounced, synchronised button level.
- rise_out  output  1  one-cycle pulse when level_out goes 0→1.
- fall_out  output  1  one-cycle pulse when level_out goes 1→0.
- press_count  output  COUNT_WIDTH  number of accepted presses (rises), modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (reset=0, asynchronous): the following are all 0 immediately, independent of clk:
  - every synchroniser flop;
  - debounce counter;
  - level_out, rise_out, fall_out;
  - press_count.
  State is STABLE_LOW. Reset release takes effect on the next rising edge.
- Synchroniser: a SYNC_STAGES-deep flop chain clocked by clk. Its last stage, sync, is the only signal the FSM reads. No other logic touches btn_in.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. Counter cnt is $clog2(DEBOUNCE_CYCLES) bits wide.
  - STABLE_LOW: sync=1 → WAIT_HIGH, cnt←1. Otherwise hold, cnt←0.
  - WAIT_HIGH:
    - sync=0 → STABLE_LOW, cnt←0. Glitch rejected; no output change.
    - sync=1 and cnt==DEBOUNCE_CYCLES-1 → STABLE_HIGH, cnt←0, level_out←1, rise_out←1, press_count←press_count+1.
    - Otherwise cnt←cnt+1.
  - STABLE_HIGH and WAIT_LOW: mirror image with sync=0. Acceptance sets level_out←0 and fall_out←1. press_count is unchanged on release.
- Pulses: rise_out and fall_out are registered and high for exactly one cycle. They are never high together. In all cycles other than the acceptance cycle they are 0.
- Latency: a clean btn_in transition first sampled at rising edge E appears on level_out after edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults, that is the 6th edge counting E.
- Rejection: any excursion that holds sync at the new value for fewer than DEBOUNCE_CYCLES consecutive cycles produces no change in level_out, the pulses or press_count. A bounce restarts the count from 1 on the next change.
- Wrap: press_count wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- Reset mid-operation:
  - Asserting reset in a WAIT state discards the pending count.
  - If btn_in is held high through reset release, it is treated as a new press. rise_out fires and press_count becomes 1 after the full latency, measured from the first edge after release.
- No combinational path from btn_in to any output.

Test Plan:
Defaults, 10 ns clock.
1. Reset: reset=0 with btn_in=1 → level_out=0, rise_out=0, fall_out=0, press_count=0 immediately, with no clock edge needed.
2. Clean press: reset=1, btn_in 0→1 before edge E, held → level_out=1 and rise_out=1 after edge E+5. rise_out=0 after E+6. press_count=1.
3. Glitch reject: btn_in high for 3 cycles, then low → level_out stays 0, no pulse, press_count unchanged.
4. Bounce then settle: btn_in toggles 1,0,1,0 on successive cycles, then stays 1 → exactly one rise_out. It occurs 6 edges after the final 0→1 sample. press_count increments by 1.
5. Release: from STABLE_HIGH, btn_in→0 held → fall_out one cycle, level_out=0 after 6 edges, press_count unchanged.
6. Wrap and mid-reset: perform 256 clean presses → press_count returns to 0. Assert reset during WAIT_HIGH → all outputs 0, and no pulse follows unless btn_in remains high after release.
